// File: rtl/uart_rx.sv
// 8N1 serial receiver, MSB-first, 16x oversampled with 3-sample majority vote.
// Partner of uart_tx; delivers each byte as a one-clock valid pulse plus framing flag.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] MID_LO = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] MID    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] MID_HI = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic [1:0]           smp_q, smp_d;
    logic                 ferr_q, ferr_d;
    logic                 valid_q, valid_d;
    logic                 meta_q, rxs_q, prev_q;
    logic                 vote, at_vote;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            smp_q   <= '0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            meta_q  <= 1'b1;
            rxs_q   <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            meta_q  <= rx;
            rxs_q   <= meta_q;
            if (baud_tick) prev_q <= rxs_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            smp_q   <= smp_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end

    // The third sample is the live synchronized line on the vote tick.
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    assign at_vote = (tick_q == MID_HI);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        smp_d   = smp_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;
        if (baud_tick) begin
            if (state_q != IDLE) begin
                tick_d = tick_q + 1'b1;
                if (tick_q == MID_LO) smp_d[0] = rxs_q;
                if (tick_q == MID)    smp_d[1] = rxs_q;
            end
            unique case (state_q)
                IDLE: begin
                    if (prev_q && !rxs_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (at_vote && vote) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else if (tick_q == LAST) begin
                        state_d = DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (at_vote) shift_d = {shift_q[DATA_BITS-2:0], vote};
                    if (tick_q == LAST) begin
                        tick_d = '0;
                        if (bit_q == BLAST) state_d = STOP;
                        else                bit_d   = bit_q + 1'b1;
                    end
                end
                STOP: begin
                    // Leave half a bit early so a back-to-back start edge is seen.
                    if (at_vote) begin
                        dout_d  = shift_q;
                        ferr_d  = ~vote;
                        valid_d = 1'b1;
                        state_d = IDLE;
                        tick_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule
